// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix row scanner with column synchronizer, debounce and one-shot press pulse
module keypad_scanner #(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic       press,
    output logic [3:0] scan_code,
    output logic       key_held
);
    localparam int TW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DT = DW'(DEBOUNCE_TICKS);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
    state_t          state;
    logic [TW-1:0]   tcnt;
    logic            tick;
    logic [3:0]      s1, cs;
    logic [1:0]      r, c, lo;
    logic [DW-1:0]   dcnt, dnext;
    logic            down;
    assign tick    = tcnt == TMAX;
    assign row_out = ~(4'b0001 << r);
    assign down    = ~cs[c];
    assign dnext   = dcnt + DW'(1);
    // lowest-numbered active-low column in the sampled row
    always_comb lo = ~cs[0] ? 2'd0 : ~cs[1] ? 2'd1 : ~cs[2] ? 2'd2 : 2'd3;
    // free-running scan tick divider
    always_ff @(posedge clk or posedge rst)
        if (rst) tcnt <= '0;
        else     tcnt <= tick ? '0 : tcnt + TW'(1);
    // two-flop synchronizer for the asynchronous column returns
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1 <= 4'hF;
            cs <= 4'hF;
        end else begin
            s1 <= col_in;
            cs <= s1;
        end
    // scan / debounce / hold / release sequencing with registered outputs
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= SCAN;
            r         <= 2'd0;
            c         <= 2'd0;
            dcnt      <= '0;
            press     <= 1'b0;
            scan_code <= 4'h0;
            key_held  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (tick)
                case (state)
                    SCAN:
                        if (cs != 4'hF) begin
                            c    <= lo;
                            dcnt <= DW'(1);
                            if (DEBOUNCE_TICKS == 1) begin
                                state     <= HELD;
                                press     <= 1'b1;
                                scan_code <= {r, lo};
                                key_held  <= 1'b1;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end else begin
                            r <= r + 2'd1;
                        end
                    DEBOUNCE:
                        if (down) begin
                            dcnt <= dnext;
                            if (dnext == DT) begin
                                state     <= HELD;
                                press     <= 1'b1;
                                scan_code <= {r, c};
                                key_held  <= 1'b1;
                            end
                        end else begin
                            state <= SCAN;
                            r     <= r + 2'd1;
                        end
                    HELD:
                        if (!down) begin
                            dcnt <= DW'(1);
                            if (DEBOUNCE_TICKS == 1) begin
                                state    <= SCAN;
                                key_held <= 1'b0;
                                r        <= r + 2'd1;
                            end else begin
                                state <= RELEASE;
                            end
                        end
                    RELEASE:
                        if (!down) begin
                            dcnt <= dnext;
                            if (dnext == DT) begin
                                state    <= SCAN;
                                key_held <= 1'b0;
                                r        <= r + 2'd1;
                            end
                        end else begin
                            state <= HELD;
                        end
                    default: state <= SCAN;
                endcase
        end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized keypad stimulus checked every cycle against a tick-level reference model
module tb_keypad_scanner;
    localparam int CD = 4;
    localparam int DT = 3;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col_in, row_out, scan_code;
    logic       press, key_held;
    logic [15:0] keys = 16'h0;
    int checks = 0, failures = 0, npress = 0;
    keypad_scanner #(.CLK_DIV(CD), .DEBOUNCE_TICKS(DT)) dut (
        .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
        .press(press), .scan_code(scan_code), .key_held(key_held)
    );
    always #5 clk = ~clk;
    // physical keypad: a pressed key shorts its column to its row when that row is driven low
    always_comb
        for (int c = 0; c < 4; c++) begin
            col_in[c] = 1'b1;
            for (int r = 0; r < 4; r++)
                if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
        end
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask
    // reference model: per-tick key tracking with run lengths of consecutive down/up samples
    int tc, m_row, kc, run;
    bit locked, acc, e_press, e_held;
    int e_code;
    logic [3:0] sy1, sy2, cs;
    always @(posedge clk or posedge rst)
        if (rst) begin
            tc = 0; sy1 = 4'hF; sy2 = 4'hF; m_row = 0; kc = 0; run = 0;
            locked = 0; acc = 0; e_press = 0; e_held = 0; e_code = 0;
        end else begin
            cs = sy2; sy2 = sy1; sy1 = col_in;
            e_press = 0;
            if (tc == CD - 1) begin
                tc = 0;
                if (!locked) begin
                    if (cs != 4'hF) begin
                        kc = 3;
                        for (int i = 3; i >= 0; i--) if (!cs[i]) kc = i;
                        locked = 1; run = 1;
                        if (run >= DT) begin acc = 1; run = 0; e_press = 1; e_code = m_row*4 + kc; e_held = 1; end
                    end else m_row = (m_row + 1) % 4;
                end else if (!acc) begin
                    if (!cs[kc]) begin
                        run++;
                        if (run >= DT) begin acc = 1; run = 0; e_press = 1; e_code = m_row*4 + kc; e_held = 1; end
                    end else begin
                        locked = 0; m_row = (m_row + 1) % 4;
                    end
                end else begin
                    if (cs[kc]) begin
                        run++;
                        if (run >= DT) begin locked = 0; acc = 0; e_held = 0; m_row = (m_row + 1) % 4; end
                    end else run = 0;
                end
            end else tc++;
        end
    // count observed press pulses for the directed scenarios
    always @(posedge clk) if (press) npress++;
    // compare every output mid-cycle
    always @(negedge clk) begin
        chk("row_out", row_out, 4'hF ^ (4'd1 << m_row));
        chk("press", press, e_press);
        chk("scan_code", scan_code, e_code);
        chk("key_held", key_held, e_held);
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic reset_pulse(input int n);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_row", row_out, 4'b1110);
        chk("rst_press", press, 0);
        chk("rst_code", scan_code, 0);
        chk("rst_held", key_held, 0);
        cyc(n);
        #1 rst = 1'b0;
    endtask
    initial begin
        int p0, hold;
        reset_pulse(3);
        cyc(20);
        p0 = npress;
        keys = 16'h0200;
        cyc(40);
        chk("clean_npress", npress - p0, 1);
        chk("clean_code", scan_code, 4'h9);
        chk("clean_held", key_held, 1);
        chk("clean_row", row_out, 4'b1011);
        reset_pulse(2);
        p0 = npress;
        cyc(12);
        chk("rereq_none", npress - p0, 0);
        cyc(28);
        chk("rereq_npress", npress - p0, 1);
        keys = 16'h0;
        cyc(30);
        chk("release_held", key_held, 0);
        p0 = npress;
        keys = 16'h000A;
        cyc(40);
        chk("multi_npress", npress - p0, 1);
        chk("multi_code", scan_code, 4'h1);
        keys = 16'h0;
        cyc(30);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) reset_pulse($urandom_range(1, 4));
            keys = 16'h0;
            keys[$urandom_range(0, 15)] = 1'b1;
            if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
            hold = $urandom_range(0, 1) ? $urandom_range(2, 14) : $urandom_range(15, 60);
            cyc(hold);
            if ($urandom_range(0, 3) == 0) begin
                keys = 16'h0;
                cyc($urandom_range(1, 8));
                keys[$urandom_range(0, 15)] = 1'b1;
                cyc($urandom_range(10, 40));
            end
            keys = 16'h0;
            cyc($urandom_range(4, 50));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Front end of the keyboard datapath. Drives a 4x4 matrix keypad by row scanning, synchronizes and debounces the column returns, and delivers each accepted keystroke as a one-cycle `press` pulse with a 4-bit `scan_code`. This is the producer side of the `press`/`scan_code` interface consumed by the key buffer. Each physical key press yields exactly one pulse regardless of contact bounce or hold duration.

## Interface
- `CLK_DIV`, default 50000: scan tick period in clk cycles. Minimum 4.
- `DEBOUNCE_TICKS`, default 4: number of consecutive ticks required to accept a press or a release. Minimum 1.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high. The clock is `clk`.
- `col_in` input 4: keypad columns, active-low (pulled up), asynchronous to `clk`.
- `row_out` output 4: keypad row drive, active-low one-hot.
- `press` output 1: one-`clk`-cycle pulse per accepted key.
- `scan_code` output 4: code of the last accepted key, `{row[1:0], col[1:0]}`. Valid from the `press` cycle and held until the next press.
- `key_held` output 1: high while an accepted key remains down, including during release debounce.

## Operation
- Tick generator: counter 0..CLK_DIV-1. `tick`=1 in the cycle where count==CLK_DIV-1, then the counter wraps to 0. It runs continuously in every state.
- `col_in` passes through a 2-flop synchronizer. All decisions use the synchronized value `cs`. "Key down" means `cs[col]`==0 for the latched column.
- Row index `r` (2 bits); `row_out` = ~(4'b0001 << r).
- States: SCAN, DEBOUNCE, HELD, RELEASE. Counter `dcnt` is sized for DEBOUNCE_TICKS.
- SCAN, on tick:
  - If `cs`!=4'hF: latch `r` and `c` = lowest index with `cs[c]`==0. Set `dcnt`=1. Freeze `r`. Go to DEBOUNCE. If DEBOUNCE_TICKS==1, go directly to HELD and fire `press`.
  - Otherwise `r`<=`r`+1 (wraps 3->0).
- DEBOUNCE, on tick:
  - If key down: `dcnt`++. When the incremented value reaches DEBOUNCE_TICKS, go to HELD and fire `press`.
  - If the key is up: go to SCAN, `r`<=`r`+1, no press.
- HELD: `key_held`=1, `r` frozen. On a tick with the key up, set `dcnt`=1 and go to RELEASE.
- RELEASE, on tick:
  - Key up: `dcnt`++. On reaching DEBOUNCE_TICKS, go to SCAN, `key_held`<=0, `r`<=`r`+1.
  - Key down: return to HELD, no new press.
- Other columns in the frozen row going low during DEBOUNCE/HELD/RELEASE are ignored. There is no rollover.
- `scan_code` and `press` are registered. They update in the cycle after the qualifying tick.
- Reset values: `row_out`=4'b1110, `press`=0, `scan_code`=4'h0, `key_held`=0, state SCAN, `r`=0, tick counter 0, `dcnt`=0, synchronizer flops 4'hF.

## Timing
- Row change: `row_out` updates in the cycle after a tick. Columns then have CLK_DIV-1 cycles to settle before the next sample.
- Column-to-`cs` latency: 2 cycles.
- Press latency: `press` rises 1 cycle after the tick on which the count reaches DEBOUNCE_TICKS. That is (DEBOUNCE_TICKS-1)*CLK_DIV+1 cycles after the detection tick.
- `press` is high for exactly 1 cycle and never repeats while a key is held.
- Minimum release-to-next-press spacing: DEBOUNCE_TICKS ticks of release, plus scan to the row, plus DEBOUNCE_TICKS ticks of press.
- `rst` mid-operation: all outputs return to reset values immediately. A key still down after deassert must re-qualify through SCAN/DEBOUNCE before any `press`.

## Test plan
All scenarios use CLK_DIV=4 and DEBOUNCE_TICKS=3.
- Reset/idle: pulse `rst`, hold `col_in`=4'hF -> `row_out` sequence 1110, 1101, 1011, 0111, 1110, changing every 4 cycles. `press`=0, `scan_code`=0, `key_held`=0.
- Clean press: hold row 2/col 1 low (col_in=4'b1101 while row_out=1011) for 40 cycles -> exactly one `press`, 9 cycles after the detection tick. `scan_code`=4'h9, `key_held`=1, `row_out` frozen at 1011.
- Press bounce: same key low for only 2 ticks, then high -> no `press`, `scan_code` unchanged, scanning resumes at row 3.
- Release bounce: from HELD, col high 1 tick then low again -> no second `press`, `key_held` stays 1. Then high for 3 ticks -> `key_held`=0, scanning resumes.
- Multi-column: row 0 with cols 1 and 3 low (col_in=4'b0101) -> single `press`, `scan_code`=4'h1.
- Reset mid-HELD: assert `rst` while key 4'h9 is held -> outputs return to reset values that cycle. After deassert, with the key still held, a new `press` occurs only after full re-debounce.
